rally_pacer: RTL and testbench

Game-pacing scheduler for the Pong datapath. It generates the `tick` that steps the ball shift register and the `serve` pulse that loads it. It shortens the tick period as a rally lengthens and restores it after every point. It sits between the push-button/score logic and the ball datapath, replacing a fixed-rate timer with a rally-aware schedule.

---
 rtl/rally_pacer.sv | 177 +++++++++++++++++
 tb/tb_rally_pacer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rally_pacer.sv
// Rally-aware tick/serve scheduler for the Pong ball datapath.
// Define RALLY_PACER_SPEEDUP_EN to compile in the hit-driven speed-up; otherwise the tick period stays fixed.
module rally_pacer #(
    parameter int unsigned PERIOD_W      = 26,
    parameter int unsigned START_PERIOD  = 12_500_000,
    parameter int unsigned MIN_PERIOD    = 2_500_000,
    parameter int unsigned STEP          = 1_250_000,
    parameter int unsigned HITS_PER_STEP = 4,
    parameter int unsigned SERVE_DLY     = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       hit_i,
    input  logic       miss_l_i,
    input  logic       miss_r_i,
    input  logic       over_i,
    output logic       tick_o,
    output logic       serve_o,
    output logic       serve_dir_o,
    output logic [3:0] level_o,
    output logic [2:0] state_o
);

    // state       | meaning
    // IDLE        | waiting for start after reset
    // SERVE_WAIT  | counting SERVE_DLY period expiries before the serve
    // RALLY       | ball in play, tick every per clocks
    // POINT       | one cycle for the score logic to settle before sampling over
    // GAMEOVER    | match decided, waiting for start
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_RALLY      = 3'd2,
        ST_POINT      = 3'd3,
        ST_GAMEOVER   = 3'd4
    } state_t;

    localparam logic [PERIOD_W-1:0] START_P  = PERIOD_W'(START_PERIOD);
    localparam int unsigned         DLY_W    = $clog2(SERVE_DLY + 1);
    localparam logic [DLY_W-1:0]    DLY_LAST = DLY_W'(SERVE_DLY);

    state_t              state_q;
    logic                tick_q;
    logic                serve_q;
    logic                serve_dir_q;
    logic [3:0]          level_q;
    logic [PERIOD_W-1:0] per_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic [DLY_W-1:0]    dly_q;
    logic [PERIOD_W-1:0] per_m1;
    logic [DLY_W-1:0]    dly_inc;

    assign per_m1  = per_q - PERIOD_W'(1);
    assign dly_inc = dly_q + DLY_W'(1);

`ifdef RALLY_PACER_SPEEDUP_EN
    localparam int unsigned         HITS_W = $clog2(HITS_PER_STEP + 1);
    localparam logic [HITS_W-1:0]   HITS_LAST = HITS_W'(HITS_PER_STEP);
    localparam logic [PERIOD_W-1:0] MIN_P  = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] STEP_P = PERIOD_W'(STEP);

    logic [HITS_W-1:0]   hits_q;
    logic [HITS_W-1:0]   hits_inc;
    logic [PERIOD_W-1:0] step_per;
    logic [3:0]          step_level;
    logic [3:0]          level_sat;

    always_comb begin
        hits_inc   = hits_q + HITS_W'(1);
        level_sat  = (level_q == 4'hF) ? level_q : level_q + 4'd1;
        step_per   = MIN_P;
        step_level = level_sat;
        if (per_q >= MIN_P + STEP_P) begin
            step_per = per_q - STEP_P;
        end else if (per_q == MIN_P) begin
            step_level = level_q;
        end
    end
`else
    logic unused_hit;
    assign unused_hit = hit_i;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            tick_q      <= 1'b0;
            serve_q     <= 1'b0;
            serve_dir_q <= 1'b0;
            level_q     <= 4'd0;
            per_q       <= START_P;
            cnt_q       <= '0;
            dly_q       <= '0;
`ifdef RALLY_PACER_SPEEDUP_EN
            hits_q      <= '0;
`endif
        end else begin
            tick_q  <= 1'b0;
            serve_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_GAMEOVER: begin
                    if (start_i) begin
                        state_q     <= ST_SERVE_WAIT;
                        per_q       <= START_P;
                        level_q     <= 4'd0;
                        serve_dir_q <= 1'b1;
                        cnt_q       <= START_P - PERIOD_W'(1);
                        dly_q       <= '0;
`ifdef RALLY_PACER_SPEEDUP_EN
                        hits_q      <= '0;
`endif
                    end
                end
                ST_SERVE_WAIT: begin
                    if (cnt_q == '0) begin
                        cnt_q <= per_m1;
                        dly_q <= dly_inc;
                        if (dly_inc == DLY_LAST) begin
                            serve_q <= 1'b1;
                            state_q <= ST_RALLY;
                        end
                    end else begin
                        cnt_q <= cnt_q - PERIOD_W'(1);
                    end
                end
                ST_RALLY: begin
                    // A miss ends the rally outright: no tick, and any same-cycle hit is dropped.
                    if (miss_l_i || miss_r_i) begin
                        state_q     <= ST_POINT;
                        serve_dir_q <= miss_l_i;
                        per_q       <= START_P;
                        level_q     <= 4'd0;
`ifdef RALLY_PACER_SPEEDUP_EN
                        hits_q      <= '0;
`endif
                    end else begin
                        if (cnt_q == '0) begin
                            tick_q <= 1'b1;
                            cnt_q  <= per_m1;
                        end else begin
                            cnt_q <= cnt_q - PERIOD_W'(1);
                        end
`ifdef RALLY_PACER_SPEEDUP_EN
                        if (hit_i) begin
                            if (hits_inc == HITS_LAST) begin
                                hits_q  <= '0;
                                per_q   <= step_per;
                                level_q <= step_level;
                            end else begin
                                hits_q <= hits_inc;
                            end
                        end
`endif
                    end
                end
                ST_POINT: begin
                    if (over_i) begin
                        state_q <= ST_GAMEOVER;
                    end else begin
                        state_q <= ST_SERVE_WAIT;
                        cnt_q   <= per_m1;
                        dly_q   <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tick_o      = tick_q;
    assign serve_o     = serve_q;
    assign serve_dir_o = serve_dir_q;
    assign level_o     = level_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_rally_pacer.sv
// Directed bench for rally_pacer with small periods (start 20, min 8, step 4, 2 hits/step, 2 serve delays).
// Speed-related expectations follow RALLY_PACER_SPEEDUP_EN as seen by this file.
module tb_rally_pacer;

`ifdef RALLY_PACER_SPEEDUP_EN
    localparam bit SP = 1'b1;
`else
    localparam bit SP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic       miss_l = 1'b0;
    logic       miss_r = 1'b0;
    logic       over = 1'b0;
    logic       tick;
    logic       serve;
    logic       serve_dir;
    logic [3:0] level;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_log[$];
    int serve_log[$];

    rally_pacer #(
        .PERIOD_W(26), .START_PERIOD(20), .MIN_PERIOD(8), .STEP(4),
        .HITS_PER_STEP(2), .SERVE_DLY(2)
    ) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .hit_i(hit),
        .miss_l_i(miss_l), .miss_r_i(miss_r), .over_i(over),
        .tick_o(tick), .serve_o(serve), .serve_dir_o(serve_dir),
        .level_o(level), .state_o(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tick)  tick_log.push_back(cyc);
        if (serve) serve_log.push_back(cyc);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    function automatic int tk(input int i);
        return (i < tick_log.size()) ? tick_log[i] : -1000;
    endfunction

    function automatic int sv(input int i);
        return (i < serve_log.size()) ? serve_log[i] : -1000;
    endfunction

    task automatic wait_log(input bit is_serve, input int n, input string tag);
        int k = 0;
        while (((is_serve ? serve_log.size() : tick_log.size()) < n) && k < 300) begin
            nxt();
            k++;
        end
        check(tag, int'((is_serve ? serve_log.size() : tick_log.size()) >= n), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, tb, u, v, s, w, pe, nt, ns;
        int lvl_exp[8] = '{0, 1, 1, 2, 2, 3, 3, 3};

        // reset values
        repeat (3) nxt();
        reset = 1'b0;
        check("rst_state", int'(state), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_serve", int'(serve), 0);
        check("rst_dir", int'(serve_dir), 0);
        check("rst_level", int'(level), 0);
        tick_log.delete();
        serve_log.delete();

        // start -> serve 41 cycles later, then ticks every 20
        nxt();
        start = 1'b1;
        t0 = cyc;
        nxt();
        start = 1'b0;
        check("start_state", int'(state), 1);
        wait_log(1'b1, 1, "serve0_timeout");
        check("serve0_lat", sv(0) - t0, 41);
        check("serve0_dir", int'(serve_dir), 1);
        check("serve0_state", int'(state), 2);
        nxt();
        check("serve0_width", int'(serve), 0);
        wait_log(1'b0, 3, "tick0_timeout");
        check("tick0_gap", tk(0) - sv(0), 20);
        check("tick1_gap", tk(1) - tk(0), 20);
        check("tick2_gap", tk(2) - tk(1), 20);

        // 8 hits spaced 3 cycles: levels 1,2,3,3 and period 8 after the next reload
        tb = tk(2);
        for (int i = 0; i < 8; i++) begin
            nxt();
            hit = 1'b1;
            nxt();
            hit = 1'b0;
            check("hit_level", int'(level), SP ? lvl_exp[i] : 0);
            nxt();
        end
        wait_log(1'b0, 6, "tick_speed_timeout");
        check("tick3_gap", tk(3) - tb, 20);
        check("tick4_gap", tk(4) - tk(3), SP ? 8 : 20);
        check("tick5_gap", tk(5) - tk(4), SP ? 8 : 20);

        // miss_r, over low -> POINT then SERVE_WAIT, speed restored
        u = tk(5);
        nxt();
        miss_r = 1'b1;
        nxt();
        miss_r = 1'b0;
        check("missr_state", int'(state), 3);
        check("missr_dir", int'(serve_dir), 0);
        check("missr_level", int'(level), 0);
        nxt();
        check("missr_next", int'(state), 1);
        pe = cyc;
        wait_log(1'b1, 2, "serve1_timeout");
        check("serve1_lat", sv(1) - pe, 40);
        check("no_tick_wait", tick_log.size(), 6);
        wait_log(1'b0, 8, "tick_after_miss_timeout");
        check("tick6_gap", tk(6) - sv(1), 20);
        check("tick7_gap", tk(7) - tk(6), 20);

        // both misses with over high -> left wins, GAMEOVER, silent
        v = tk(7);
        nxt();
        miss_l = 1'b1;
        miss_r = 1'b1;
        over = 1'b1;
        nxt();
        miss_l = 1'b0;
        miss_r = 1'b0;
        check("dblmiss_state", int'(state), 3);
        check("dblmiss_dir", int'(serve_dir), 1);
        nxt();
        check("gameover_state", int'(state), 4);
        over = 1'b0;
        nt = tick_log.size();
        ns = serve_log.size();
        repeat (200) nxt();
        check("gameover_ticks", tick_log.size(), nt);
        check("gameover_serves", serve_log.size(), ns);
        check("gameover_hold", int'(state), 4);
        nxt();
        start = 1'b1;
        t1 = cyc;
        nxt();
        start = 1'b0;
        check("restart_state", int'(state), 1);
        check("restart_dir", int'(serve_dir), 1);
        wait_log(1'b1, 3, "serve2_timeout");
        check("serve2_lat", sv(2) - t1, 41);

        // hit then hit+miss_l in the same cycle: miss wins, hit count cleared
        s = sv(2);
        nxt();
        hit = 1'b1;
        nxt();
        hit = 1'b0;
        nxt();
        hit = 1'b1;
        miss_l = 1'b1;
        nxt();
        hit = 1'b0;
        miss_l = 1'b0;
        check("hitmiss_state", int'(state), 3);
        check("hitmiss_level", int'(level), 0);
        nxt();
        check("hitmiss_next", int'(state), 1);
        pe = cyc;
        wait_log(1'b1, 4, "serve3_timeout");
        check("serve3_lat", sv(3) - pe, 40);
        w = sv(3);
        nxt();
        hit = 1'b1;
        nxt();
        hit = 1'b0;
        check("hits_cleared", int'(level), 0);
        nxt();
        hit = 1'b1;
        nxt();
        hit = 1'b0;
        check("second_hit_step", int'(level), SP ? 1 : 0);

        // reset 5 cycles before the tick expected at w+20
        nt = tick_log.size();
        ns = serve_log.size();
        while (cyc < w + 14) nxt();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        check("midrst_state", int'(state), 0);
        check("midrst_tick", int'(tick), 0);
        check("midrst_serve", int'(serve), 0);
        check("midrst_dir", int'(serve_dir), 0);
        check("midrst_level", int'(level), 0);
        repeat (40) nxt();
        check("midrst_no_tick", tick_log.size(), nt);
        check("midrst_no_serve", serve_log.size(), ns);
        check("midrst_idle", int'(state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
